// File: rtl/dec_gray_pkg.sv
// dec_gray_pkg: shared defaults and code-conversion helpers for the Gray-to-thermometer pipeline.
package dec_gray_pkg;
    localparam int DEF_GW        = 5;
    localparam int DEF_MAX_STEP  = 4;
    localparam int DEF_REJ_LIMIT = 2;
    localparam int DEF_CW        = 16;
    localparam int MAX_GW        = 8;
    localparam int MAX_TW        = 2**MAX_GW;
    typedef logic [MAX_GW-1:0] code_t;
    typedef logic [MAX_TW-1:0] therm_t;
    // Zero upper bits leave the prefix XOR of the low bits untouched, so one width serves every GW.
    function automatic code_t gray2bin(input code_t g);
        code_t b;
        b = g;
        for (int i = 1; i < MAX_GW; i++) b = b ^ (g >> i);
        return b;
    endfunction
    function automatic therm_t bin2therm(input code_t b);
        return (therm_t'(1) << b) - therm_t'(1);
    endfunction
endpackage

// File: rtl/dec_gray_therm_pipe_sparkle_filter.sv
// sparkle_filter: tracks the last accepted code and substitutes it for samples that jump too far.
module sparkle_filter #(
    parameter int GW        = 5,
    parameter int MAX_STEP  = 4,
    parameter int REJ_LIMIT = 2,
    parameter int CW        = 16
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_filt,
    input  logic [GW-1:0] i_bin,
    output logic [GW-1:0] o_value,
    output logic          o_spark,
    output logic [CW-1:0] o_rej_cnt
);
    localparam int RW = $clog2(REJ_LIMIT + 1);
    logic [GW-1:0] r_prev;
    logic          r_prev_vld;
    logic [RW-1:0] r_rej_run;
    logic [CW-1:0] r_rej_cnt;
    logic [GW:0]   w_d;
    logic          w_acc;
    always_comb begin
        w_d     = (i_bin > r_prev) ? {1'b0, i_bin} - {1'b0, r_prev} : {1'b0, r_prev} - {1'b0, i_bin};
        w_acc   = !i_filt || !r_prev_vld || (int'(w_d) <= MAX_STEP) || (int'(r_rej_run) == REJ_LIMIT);
        o_value = w_acc ? i_bin : r_prev;
        o_spark = !w_acc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_rej_run  <= '0;
            r_rej_cnt  <= '0;
        end else if (i_en) begin
            if (w_acc) begin
                r_prev     <= i_bin;
                r_prev_vld <= 1'b1;
                r_rej_run  <= '0;
            end else begin
                r_rej_run <= r_rej_run + RW'(1);
                if (!(&r_rej_cnt)) r_rej_cnt <= r_rej_cnt + CW'(1);
            end
        end
    end
    assign o_rej_cnt = r_rej_cnt;
endmodule

// File: rtl/dec_gray_therm_pipe.sv
// dec_gray_therm_pipe: two-stage valid/ready Gray-to-thermometer decoder with optional sparkle filtering.
module dec_gray_therm_pipe
    import dec_gray_pkg::*;
#(
    parameter int GW        = DEF_GW,
    parameter int MAX_STEP  = DEF_MAX_STEP,
    parameter int REJ_LIMIT = DEF_REJ_LIMIT,
    parameter int CW        = DEF_CW,
    localparam int TW       = 2**GW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [GW-1:0] in_gray,
    input  logic          filt_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] out_therm,
    output logic [GW-1:0] out_bin,
    output logic          out_spark,
    output logic [CW-1:0] rej_cnt
);
    logic          w_ce;
    logic          r_s1_vld;
    logic          r_s1_filt;
    logic [GW-1:0] r_s1_bin;
    logic [GW-1:0] w_value;
    logic          w_spark;
    assign w_ce     = !out_valid || out_ready;
    assign in_ready = w_ce;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_filt <= 1'b0;
            r_s1_bin  <= '0;
            out_valid <= 1'b0;
            out_therm <= '0;
            out_bin   <= '0;
            out_spark <= 1'b0;
        end else if (w_ce) begin
            r_s1_vld  <= in_valid;
            r_s1_filt <= filt_en;
            r_s1_bin  <= GW'(gray2bin(code_t'(in_gray)));
            out_valid <= r_s1_vld;
            if (r_s1_vld) begin
                out_bin   <= w_value;
                out_therm <= TW'(bin2therm(code_t'(w_value)));
                out_spark <= w_spark;
            end
        end
    end
    sparkle_filter #(
        .GW(GW), .MAX_STEP(MAX_STEP), .REJ_LIMIT(REJ_LIMIT), .CW(CW)
    ) u_filt (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_ce && r_s1_vld),
        .i_filt    (r_s1_filt),
        .i_bin     (r_s1_bin),
        .o_value   (w_value),
        .o_spark   (w_spark),
        .o_rej_cnt (rej_cnt)
    );
endmodule

// File: tb/tb_dec_gray_therm_pipe.sv
// tb_dec_gray_therm_pipe: directed and random checks of the decoder against a queue-based reference model.
module tb_dec_gray_therm_pipe;
    localparam int GW = 5, TW = 32, CW = 16, MAX_STEP = 4, REJ_LIMIT = 2;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, filt_en, out_valid, out_ready, out_spark;
    logic [GW-1:0] in_gray, out_bin;
    logic [TW-1:0] out_therm;
    logic [CW-1:0] rej_cnt;
    logic b_rst, b_in_valid, b_in_ready, b_filt_en, b_out_valid, b_out_ready, b_out_spark;
    logic [2:0] b_in_gray, b_out_bin;
    logic [7:0] b_out_therm;
    logic [1:0] b_rej_cnt;
    always #5 clk = ~clk;

    dec_gray_therm_pipe #(.GW(GW), .MAX_STEP(MAX_STEP), .REJ_LIMIT(REJ_LIMIT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .filt_en(filt_en), .out_valid(out_valid), .out_ready(out_ready), .out_therm(out_therm),
        .out_bin(out_bin), .out_spark(out_spark), .rej_cnt(rej_cnt));

    dec_gray_therm_pipe #(.GW(3), .MAX_STEP(4), .REJ_LIMIT(8), .CW(2)) dut_s (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_gray(b_in_gray),
        .filt_en(b_filt_en), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_therm(b_out_therm),
        .out_bin(b_out_bin), .out_spark(b_out_spark), .rej_cnt(b_rej_cnt));

    typedef struct { int bin; bit spark; int cnt; int cyc; } item_t;
    item_t q[$];
    int got_bin[$];
    bit got_spark[$];
    logic [31:0] got_therm[$];
    int checks = 0, errors = 0, cyc = 0, idx;
    bit chk_lat = 0, fired;
    int m_prev, m_run, m_cnt;
    bit m_vld;
    int exp_a[4] = '{10, 12, 12, 13};
    bit spk_a[4] = '{0, 0, 1, 0};
    int exp_b[4] = '{10, 10, 10, 30};
    bit spk_b[4] = '{0, 1, 1, 0};
    bit pat[4] = '{1, 0, 0, 1};
    logic rv, rf, rr;
    logic [GW-1:0] rg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Binary value is found by searching for the code whose Gray encoding matches.
    function automatic int to_bin(input logic [GW-1:0] g);
        for (int b = 0; b < TW; b++) if (GW'(b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    function automatic logic [GW-1:0] to_gray(input int b);
        return GW'(b ^ (b >> 1));
    endfunction

    function automatic logic [31:0] therm(input int v);
        logic [31:0] t;
        for (int j = 0; j < TW; j++) t[j] = (j < v);
        return t;
    endfunction

    task automatic model_push(input logic [GW-1:0] g, input logic f);
        item_t it;
        int b, d;
        b = to_bin(g);
        d = (b > m_prev) ? b - m_prev : m_prev - b;
        it.cyc = cyc;
        if (!f || !m_vld || d <= MAX_STEP || m_run == REJ_LIMIT) begin
            it.bin = b; it.spark = 0; m_prev = b; m_vld = 1; m_run = 0;
        end else begin
            it.bin = m_prev; it.spark = 1; m_run++;
            if (m_cnt < 2**CW - 1) m_cnt++;
        end
        it.cnt = m_cnt;
        q.push_back(it);
    endtask

    task automatic cycle(input logic v, input logic [GW-1:0] g, input logic f, input logic rdy, output bit fd);
        in_valid = v; in_gray = g; filt_en = f; out_ready = rdy;
        @(negedge clk);
        fd = v && in_ready;
        check("in_ready", 32'(in_ready), 32'(!(out_valid && !rdy)));
        if (out_valid) begin
            if (q.size() == 0) check("spurious_out", 32'(out_valid), 0);
            else begin
                check("out_bin", 32'(out_bin), q[0].bin);
                check("out_therm", out_therm, therm(q[0].bin));
                check("out_spark", 32'(out_spark), 32'(q[0].spark));
                check("rej_cnt", 32'(rej_cnt), q[0].cnt);
                if (chk_lat) check("latency", cyc - q[0].cyc, 2);
                if (rdy) begin
                    got_bin.push_back(int'(out_bin));
                    got_spark.push_back(out_spark);
                    got_therm.push_back(out_therm);
                    void'(q.pop_front());
                end
            end
        end
        if (fd) model_push(g, f);
        @(posedge clk); #1; cyc++;
    endtask

    task automatic send(input int b, input logic f);
        bit fd = 0;
        for (int k = 0; k < 20 && !fd; k++) cycle(1, to_gray(b), f, 1, fd);
        check("send_accepted", 32'(fd), 1);
    endtask

    task automatic drain();
        bit fd;
        for (int k = 0; k < 20 && (q.size() != 0 || k < 3); k++) cycle(0, '0, 0, 1, fd);
        check("drain_empty", 32'(q.size()), 0);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; out_ready = 1; filt_en = 0; in_gray = '0;
        @(posedge clk); #1; rst = 0; cyc++;
        q.delete(); m_prev = 0; m_vld = 0; m_run = 0; m_cnt = 0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_rej_cnt", 32'(rej_cnt), 0);
        check("rst_out_bin", 32'(out_bin), 0);
        check("rst_out_therm", out_therm, 0);
        check("rst_out_spark", 32'(out_spark), 0);
        @(posedge clk); #1; cyc++;
    endtask

    task automatic clear_got();
        got_bin.delete(); got_spark.delete(); got_therm.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        b_rst = 1; b_in_valid = 0; b_filt_en = 0; b_in_gray = '0; b_out_ready = 1;
        do_reset();
        chk_lat = 1;
        clear_got();
        for (int b = 0; b < TW; b++) cycle(1, to_gray(b), 0, 1, fired);
        drain();
        check("sweep_count", 32'(got_bin.size()), 32);
        for (int i = 0; i < got_bin.size(); i++) check("sweep_bin", got_bin[i], i);
        clear_got();
        cycle(1, 5'b00010, 0, 1, fired);
        cycle(1, 5'b10000, 0, 1, fired);
        drain();
        check("therm_g00010", got_therm[0], 32'h0000_0007);
        check("therm_g10000", got_therm[1], 32'h7FFF_FFFF);
        chk_lat = 0;

        do_reset();
        clear_got();
        for (int i = 0; i < 4; i++) send(i == 0 ? 10 : i == 1 ? 12 : i == 2 ? 25 : 13, 1);
        drain();
        for (int i = 0; i < 4; i++) begin
            check("scnA_bin", got_bin[i], exp_a[i]);
            check("scnA_spark", 32'(got_spark[i]), 32'(spk_a[i]));
        end
        check("scnA_rej_cnt", 32'(rej_cnt), 1);

        do_reset();
        clear_got();
        send(10, 1); send(30, 1); send(30, 1); send(30, 1);
        drain();
        for (int i = 0; i < 4; i++) begin
            check("scnB_bin", got_bin[i], exp_b[i]);
            check("scnB_spark", 32'(got_spark[i]), 32'(spk_b[i]));
        end
        check("scnB_rej_cnt", 32'(rej_cnt), 2);
        send(29, 1);
        drain();
        check("scnB_after_bin", got_bin[4], 29);
        check("scnB_after_spark", 32'(got_spark[4]), 0);

        clear_got();
        idx = 0;
        for (int k = 0; k < 80 && got_bin.size() < 8; k++) begin
            cycle(idx < 8, to_gray(3 * idx + 1), 0, pat[k % 4], fired);
            if (fired) idx++;
        end
        check("bp_sent", idx, 8);
        check("bp_count", 32'(got_bin.size()), 8);
        for (int i = 0; i < got_bin.size(); i++) check("bp_bin", got_bin[i], 3 * i + 1);

        send(0, 0);
        drain();
        cycle(1, to_gray(1), 0, 1, fired);
        cycle(1, to_gray(2), 0, 1, fired);
        do_reset();
        clear_got();
        send(31, 1);
        drain();
        check("post_rst_count", 32'(got_bin.size()), 1);
        check("post_rst_bin", got_bin[0], 31);
        check("post_rst_spark", 32'(got_spark[0]), 0);

        do_reset();
        for (int k = 0; k < 400; k++) begin
            rv = $urandom_range(0, 3) != 0;
            rg = GW'($urandom_range(0, TW - 1));
            rf = $urandom_range(0, 9) < 7;
            rr = $urandom_range(0, 3) != 0;
            cycle(rv, rg, rf, rr, fired);
        end
        drain();

        @(posedge clk); #1; b_rst = 0;
        b_in_valid = 1; b_filt_en = 1; b_in_gray = 3'b000;
        @(posedge clk); #1;
        b_in_gray = 3'b100;
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
        b_in_valid = 0;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        @(negedge clk);
        check("small_rej_sat", 32'(b_rej_cnt), 3);
        check("small_spark_bin", 32'(b_out_bin), 0);
        check("small_spark", 32'(b_out_spark), 1);
        @(posedge clk); #1;
        b_in_valid = 1; b_filt_en = 0; b_in_gray = 3'b100;
        @(posedge clk); #1;
        b_in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        check("small_valid", 32'(b_out_valid), 1);
        check("small_bin7", 32'(b_out_bin), 7);
        check("small_therm7", 32'(b_out_therm), 32'h7F);
        check("small_rej_hold", 32'(b_rej_cnt), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
